// File: rtl/narwhal_vision_pkg.sv
// rtl/narwhal_vision_pkg.sv - shared types and helpers for the blob bounding-box tracker
package narwhal_vision_pkg;

    typedef logic [12:0] coord_t;
    typedef logic [19:0] count_t;

    localparam coord_t COORD_INIT_MIN = 13'h1FFF;
    localparam count_t COUNT_MAX      = 20'hFFFFF;

    typedef struct packed {
        coord_t x_min;
        coord_t x_max;
        coord_t y_min;
        coord_t y_max;
        count_t count;
    } bbox_t;

    // Empty box: min at the top of the range so the first hit always wins.
    localparam bbox_t BBOX_CLEAR = {COORD_INIT_MIN, 13'd0, COORD_INIT_MIN, 13'd0, 20'd0};

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_ARMED,
        ST_ACTIVE
    } tracker_state_t;

    function automatic bbox_t bbox_add(input bbox_t b, input coord_t x, input coord_t y);
        bbox_t r;
        r = b;
        if (x < b.x_min) r.x_min = x;
        if (x > b.x_max) r.x_max = x;
        if (y < b.y_min) r.y_min = y;
        if (y > b.y_max) r.y_max = y;
        if (b.count != COUNT_MAX) r.count = b.count + 20'd1;
        return r;
    endfunction

endpackage

// File: rtl/blob_bbox_tracker_if.sv
// rtl/blob_bbox_tracker_if.sv - per-frame result handshake between tracker and consumer
interface blob_bbox_tracker_if;
    import narwhal_vision_pkg::*;

    coord_t      box_x_min;
    coord_t      box_x_max;
    coord_t      box_y_min;
    coord_t      box_y_max;
    logic [19:0] box_count;
    logic        box_found;
    logic        box_valid;
    logic        box_ready;
    logic        overrun;

    modport master (
        output box_x_min, box_x_max, box_y_min, box_y_max,
        output box_count, box_found, box_valid, overrun,
        input  box_ready
    );

    modport slave (
        input  box_x_min, box_x_max, box_y_min, box_y_max,
        input  box_count, box_found, box_valid, overrun,
        output box_ready
    );

endinterface

// File: rtl/pixel_color_match.sv
// rtl/pixel_color_match.sv - combinational "red enough" colour threshold test
module pixel_color_match #(
    parameter logic [7:0] R_MIN = 8'd150,
    parameter logic [7:0] G_MAX = 8'd90,
    parameter logic [7:0] B_MAX = 8'd90
) (
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic       match
);

    assign match = (r >= R_MIN) && (g <= G_MAX) && (b <= B_MAX);

endmodule

// File: rtl/blob_bbox_tracker.sv
// rtl/blob_bbox_tracker.sv - accumulates the bounding box of matching pixels per frame
module blob_bbox_tracker
    import narwhal_vision_pkg::*;
#(
    parameter logic [7:0]  R_MIN      = 8'd150,
    parameter logic [7:0]  G_MAX      = 8'd90,
    parameter logic [7:0]  B_MAX      = 8'd90,
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter logic [19:0] MIN_PIXELS = 20'd64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iVGA_HS,
    input  logic                iVGA_VS,
    input  coord_t              x_count,
    input  coord_t              y_count,
    input  logic [7:0]          iR,
    input  logic [7:0]          iG,
    input  logic [7:0]          iB,
    blob_bbox_tracker_if.master bus
);

    localparam coord_t H_LIM = coord_t'(H_ACTIVE);
    localparam coord_t V_LIM = coord_t'(V_ACTIVE);

    tracker_state_t state_q, state_d;
    bbox_t          acc_q, acc_d;
    bbox_t          res_q, res_d;
    logic           found_q, found_d;
    logic           valid_q, valid_d;
    logic           overrun_q, overrun_d;

    logic color_match;
    logic pixel_hit;

    pixel_color_match #(
        .R_MIN (R_MIN),
        .G_MAX (G_MAX),
        .B_MAX (B_MAX)
    ) u_color_match (
        .r     (iR),
        .g     (iG),
        .b     (iB),
        .match (color_match)
    );

    // VS is part of the qualifier, so the commit cycle never counts a pixel.
    assign pixel_hit = iVGA_HS && iVGA_VS && (x_count < H_LIM) && (y_count < V_LIM)
                       && color_match;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        res_d     = res_q;
        found_d   = found_q;
        valid_d   = valid_q && !bus.box_ready;
        overrun_d = overrun_q;

        case (state_q)
            ST_SYNC: begin
                acc_d = BBOX_CLEAR;
                if (!iVGA_VS) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                acc_d = BBOX_CLEAR;
                if (iVGA_VS) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!iVGA_VS) begin
                    state_d = ST_ARMED;
                    acc_d   = BBOX_CLEAR;
                    res_d   = acc_q;
                    found_d = (acc_q.count >= MIN_PIXELS);
                    valid_d = 1'b1;
                    // An ack landing on the commit edge consumed the old result.
                    if (valid_q && !bus.box_ready) overrun_d = 1'b1;
                end else if (pixel_hit) begin
                    acc_d = bbox_add(acc_q, x_count, y_count);
                end
            end
            default: begin
                state_d = ST_SYNC;
                acc_d   = BBOX_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SYNC;
            acc_q     <= BBOX_CLEAR;
            res_q     <= BBOX_CLEAR;
            found_q   <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            found_q   <= found_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.box_x_min = res_q.x_min;
    assign bus.box_x_max = res_q.x_max;
    assign bus.box_y_min = res_q.y_min;
    assign bus.box_y_max = res_q.y_max;
    assign bus.box_count = res_q.count;
    assign bus.box_found = found_q;
    assign bus.box_valid = valid_q;
    assign bus.overrun   = overrun_q;

endmodule
